simon_autoplayer: RTL and testbench
===================================

SIMON_AUTOPLAYER -- requirements
Module: simon_autoplayer

Interface
REQ-001 Parameter PRESS_CYCLES, default 4: cycles each replayed button is held asserted.
REQ-002 Parameter GAP_CYCLES, default 4: cycles of all-buttons-released after each press.
REQ-003 Parameter MAX_LEN, default 16: sequence storage depth, 2 bits per entry.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset is synchronous and active-low.
REQ-006 Port go, input, 1: request to start a game; rising edge is detected internally.
REQ-007 Port inject_fault, input, 1: fault-injection request; used only with REQ-031.
REQ-008 Port colour_in, input, 4: game display lines, one-hot {3:blue, 2:yellow, 1:green, 0:red}.
REQ-009 Port state_in, input, 2: game state debug: 00 IDLE, 01 DISPLAY, 10 WAIT, 11 CHECK.
REQ-010 Port btn_out, output, 4: button drive to the game, one-hot or zero.
REQ-011 Port start_out, output, 1: game start strobe.
REQ-012 Port seq_len, output, 5: number of entries captured in the current round.
REQ-013 Port err, output, 1: sticky error flag.
REQ-014 Port busy, output, 1: high whenever FSM is not in AP_IDLE.

Function
REQ-015 colour_in and state_in SHALL each pass through a 2-flop synchronizer before any use; all latencies below are counted from synchronized values.
REQ-016 FSM states SHALL be AP_IDLE, AP_START, AP_CAPTURE, AP_ARM, AP_PRESS, AP_GAP, AP_WAITCHK.
REQ-017 AP_IDLE: on go rising edge -> AP_START; start_out high for exactly 1 cycle (the AP_START cycle); then -> AP_CAPTURE.
REQ-018 AP_CAPTURE: a colour event is a transition of synchronized colour_in from 0000 to nonzero while state_in = 01.
REQ-019 A one-hot event SHALL be encoded (red 0, green 1, yellow 2, blue 3), written at index seq_len, and seq_len incremented, all in the cycle after detection.
REQ-020 A non-one-hot nonzero event SHALL set err and store nothing.
REQ-021 Event with seq_len = MAX_LEN SHALL set err, store nothing, seq_len saturates at MAX_LEN.
REQ-022 Synchronized state_in changing 01 -> 10 in AP_CAPTURE SHALL move to AP_ARM; replay index cleared.
REQ-023 AP_ARM: if seq_len = 0 set err and -> AP_WAITCHK; else -> AP_PRESS next cycle.
REQ-024 AP_PRESS: btn_out = one-hot of entry[index] for PRESS_CYCLES cycles, then -> AP_GAP.
REQ-025 AP_GAP: btn_out = 0000 for GAP_CYCLES cycles; then index+1; if index+1 = seq_len -> AP_WAITCHK, else -> AP_PRESS.
REQ-026 AP_WAITCHK: state_in = 01 -> clear seq_len, -> AP_CAPTURE (next round); state_in = 00 -> AP_IDLE (game over or lost).
REQ-027 state_in = 00 observed in AP_CAPTURE, AP_ARM, AP_PRESS or AP_GAP SHALL abort to AP_IDLE with btn_out = 0000 the next cycle; err unchanged.
REQ-028 go edges outside AP_IDLE SHALL be ignored; err clears only on reset or on AP_IDLE -> AP_START.

Reset
REQ-029 rst_n low at a clock edge SHALL force AP_IDLE, btn_out 0000, start_out 0, seq_len 0, err 0, busy 0, synchronizers and go edge detector 0, regardless of state (including mid-press).
REQ-030 Sequence storage contents need not be reset; they are never read beyond seq_len.

Configuration
REQ-031 Macro AUTOPLAY_FAULT_INJECT_EN defined: if inject_fault is high in AP_ARM, the last press of that round SHALL drive colour code (entry XOR 01) instead of entry.
REQ-032 Macro undefined: inject_fault SHALL be ignored and all presses replay stored entries exactly.

Verification
REQ-033 Reset held 2 cycles mid-AP_PRESS -> btn_out 0000, seq_len 0, err 0, busy 0 on the cycle after release.
REQ-034 go rising edge from AP_IDLE -> start_out high exactly 1 cycle, busy 1; second go edge while busy -> no further strobe.
REQ-035 state 01, colour events 0001, 0100, 1000, state -> 10 -> btn_out 0001, 0100, 1000 each for 4 cycles, separated by 4 cycles of 0000; then AP_WAITCHK.
REQ-036 colour event 0011 during DISPLAY -> err 1, seq_len unchanged; 17 valid events with MAX_LEN 16 -> err 1, seq_len 16.
REQ-037 state 10 reached with seq_len 0 -> err 1, no button asserted; state 00 during AP_GAP -> AP_IDLE, btn_out 0000.
REQ-038 With AUTOPLAY_FAULT_INJECT_EN, inject_fault 1, stored red,green -> presses 0001 then 0001 (green XOR 01 = red); without macro -> 0001 then 0010.

Source files
------------

// File: rtl/simon_game_if.sv
// ============================================================================
// Module   : simon_game_if
// Purpose  : Game-facing lines between the Simon game and its autoplayer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simon_game_if;
   logic [3:0] colour_in;
   logic [1:0] state_in;
   logic [3:0] btn_out;
   logic       start_out;

   modport master (
      input  colour_in,
      input  state_in,
      output btn_out,
      output start_out
   );

   modport slave (
      output colour_in,
      output state_in,
      input  btn_out,
      input  start_out
   );
endinterface

`default_nettype wire

// File: rtl/simon_autoplayer.sv
// ============================================================================
// Module   : simon_autoplayer
// Purpose  : Watches a Simon game's colour display, records it, replays it on
//            the buttons. AUTOPLAY_FAULT_INJECT_EN enables last-press corruption.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_autoplayer #(
   parameter int PRESS_CYCLES = 4,
   parameter int GAP_CYCLES   = 4,
   parameter int MAX_LEN      = 16
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic       go,
   input  wire logic       inject_fault,
   simon_game_if.master    game,
   output logic [4:0]      seq_len,
   output logic            err,
   output logic            busy
);

   typedef enum logic [2:0] {
      AP_IDLE    = 3'd0,
      AP_START   = 3'd1,
      AP_CAPTURE = 3'd2,
      AP_ARM     = 3'd3,
      AP_PRESS   = 3'd4,
      AP_GAP     = 3'd5,
      AP_WAITCHK = 3'd6
   } ap_state_t;

   localparam int         c_IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [4:0] c_MAX_LEN    = 5'(MAX_LEN);
   localparam logic [15:0] c_PRESS_LAST = 16'(PRESS_CYCLES - 1);
   localparam logic [15:0] c_GAP_LAST   = 16'(GAP_CYCLES - 1);

   ap_state_t   r_state;
   logic [3:0]  r_col_s1, r_col_s2, r_col_d;
   logic [1:0]  r_st_s1, r_st_s2, r_st_d;
   logic        r_go_d;
   logic [4:0]  r_seq_len;
   logic [4:0]  r_idx;
   logic [15:0] r_cnt;
   logic [3:0]  r_btn;
   logic        r_start;
   logic        r_err;
   logic [1:0]  r_mem [MAX_LEN];

   logic        w_go_rise;
   logic        w_col_evt;
   logic        w_col_onehot;
   logic [1:0]  w_col_code;
   logic        w_exit;
   logic        w_abort_lvl;
   logic        w_abort_edge;
   logic        w_full;
   logic        w_store;
   logic [4:0]  w_press_idx;
   logic [1:0]  w_code;
   logic [3:0]  w_press_btn;

   assign w_go_rise    = go & ~r_go_d;
   assign w_col_evt    = (r_col_s2 != 4'b0000) && (r_col_d == 4'b0000) && (r_st_s2 == 2'b01);
   assign w_col_onehot = ((r_col_s2 & (r_col_s2 - 4'd1)) == 4'b0000);
   assign w_exit       = (r_st_d == 2'b01) && (r_st_s2 == 2'b10);
   assign w_abort_lvl  = (r_st_s2 == 2'b00);
   // Capture is entered while the game may still report IDLE, so only a fresh drop to 00 aborts there.
   assign w_abort_edge = w_abort_lvl && (r_st_d != 2'b00);
   assign w_full       = (r_seq_len == c_MAX_LEN);
   assign w_store      = (r_state == AP_CAPTURE) && !w_abort_edge && !w_exit &&
                         w_col_evt && w_col_onehot && !w_full;

   always_comb begin
      w_col_code = 2'd0;
      case (r_col_s2)
         4'b0010: w_col_code = 2'd1;
         4'b0100: w_col_code = 2'd2;
         4'b1000: w_col_code = 2'd3;
         default: w_col_code = 2'd0;
      endcase
   end

   assign w_press_idx = (r_state == AP_GAP) ? (r_idx + 5'd1) : 5'd0;

`ifdef AUTOPLAY_FAULT_INJECT_EN
   logic r_inject;
   logic w_inject_now;
   logic w_flip;
   // The request is sampled in AP_ARM, so the first press of the round sees it directly.
   assign w_inject_now = (r_state == AP_ARM) ? inject_fault : r_inject;
   assign w_flip       = w_inject_now && ((w_press_idx + 5'd1) == r_seq_len);
   assign w_code       = r_mem[w_press_idx[c_IDX_W-1:0]] ^ {1'b0, w_flip};

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_inject <= 1'b0;
      else if (r_state == AP_ARM)
         r_inject <= inject_fault;
   end
`else
   logic w_unused;
   assign w_unused = ^{inject_fault, w_press_idx};
   assign w_code   = r_mem[w_press_idx[c_IDX_W-1:0]];
`endif

   assign w_press_btn = 4'b0001 << w_code;

   always_ff @(posedge clk) begin
      if (w_store)
         r_mem[r_seq_len[c_IDX_W-1:0]] <= w_col_code;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= AP_IDLE;
         r_col_s1  <= 4'b0000;
         r_col_s2  <= 4'b0000;
         r_col_d   <= 4'b0000;
         r_st_s1   <= 2'b00;
         r_st_s2   <= 2'b00;
         r_st_d    <= 2'b00;
         r_go_d    <= 1'b0;
         r_seq_len <= 5'd0;
         r_idx     <= 5'd0;
         r_cnt     <= 16'd0;
         r_btn     <= 4'b0000;
         r_start   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_col_s1 <= game.colour_in;
         r_col_s2 <= r_col_s1;
         r_col_d  <= r_col_s2;
         r_st_s1  <= game.state_in;
         r_st_s2  <= r_st_s1;
         r_st_d   <= r_st_s2;
         r_go_d   <= go;
         r_start  <= 1'b0;

         case (r_state)
            AP_IDLE: begin
               r_btn <= 4'b0000;
               if (w_go_rise) begin
                  r_state   <= AP_START;
                  r_start   <= 1'b1;
                  r_err     <= 1'b0;
                  r_seq_len <= 5'd0;
               end
            end
            AP_START: r_state <= AP_CAPTURE;
            AP_CAPTURE: begin
               if (w_abort_edge) begin
                  r_state <= AP_IDLE;
                  r_btn   <= 4'b0000;
               end else if (w_exit) begin
                  r_state <= AP_ARM;
                  r_idx   <= 5'd0;
               end else if (w_col_evt) begin
                  if (!w_col_onehot || w_full)
                     r_err <= 1'b1;
                  else
                     r_seq_len <= r_seq_len + 5'd1;
               end
            end
            AP_ARM: begin
               if (w_abort_lvl) begin
                  r_state <= AP_IDLE;
                  r_btn   <= 4'b0000;
               end else if (r_seq_len == 5'd0) begin
                  r_err   <= 1'b1;
                  r_state <= AP_WAITCHK;
               end else begin
                  r_state <= AP_PRESS;
                  r_btn   <= w_press_btn;
                  r_cnt   <= 16'd0;
               end
            end
            AP_PRESS: begin
               if (w_abort_lvl) begin
                  r_state <= AP_IDLE;
                  r_btn   <= 4'b0000;
               end else if (r_cnt == c_PRESS_LAST) begin
                  r_state <= AP_GAP;
                  r_btn   <= 4'b0000;
                  r_cnt   <= 16'd0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            AP_GAP: begin
               if (w_abort_lvl) begin
                  r_state <= AP_IDLE;
                  r_btn   <= 4'b0000;
               end else if (r_cnt == c_GAP_LAST) begin
                  r_idx <= r_idx + 5'd1;
                  r_cnt <= 16'd0;
                  if ((r_idx + 5'd1) == r_seq_len) begin
                     r_state <= AP_WAITCHK;
                  end else begin
                     r_state <= AP_PRESS;
                     r_btn   <= w_press_btn;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            AP_WAITCHK: begin
               r_btn <= 4'b0000;
               if (r_st_s2 == 2'b01) begin
                  r_seq_len <= 5'd0;
                  r_state   <= AP_CAPTURE;
               end else if (r_st_s2 == 2'b00) begin
                  r_state <= AP_IDLE;
               end
            end
            default: begin
               r_state <= AP_IDLE;
               r_btn   <= 4'b0000;
            end
         endcase
      end
   end

   assign game.btn_out   = r_btn;
   assign game.start_out = r_start;
   assign seq_len        = r_seq_len;
   assign err            = r_err;
   assign busy           = (r_state != AP_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_simon_autoplayer.sv
// ============================================================================
// Module   : tb_simon_autoplayer
// Purpose  : Directed self-checking bench for simon_autoplayer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simon_autoplayer;

   logic       clk;
   logic       rst_n;
   logic       go;
   logic       inject_fault;
   logic [4:0] seq_len;
   logic       err;
   logic       busy;
   int         checks;
   int         errors;

   simon_game_if gif ();

   simon_autoplayer #(
      .PRESS_CYCLES (4),
      .GAP_CYCLES   (4),
      .MAX_LEN      (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .go           (go),
      .inject_fault (inject_fault),
      .game         (gif.master),
      .seq_len      (seq_len),
      .err          (err),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic colour_event(input logic [3:0] c);
      gif.colour_in = c;
      tick(4);
      gif.colour_in = 4'b0000;
      tick(4);
   endtask

   task automatic start_game();
      go = 1'b0;
      tick(1);
      go = 1'b1;
      tick(3);
      go = 1'b0;
      tick(1);
   endtask

   task automatic wait_press(input string tag);
      int n = 0;
      while (gif.btn_out == 4'b0000 && n < 30) begin
         tick(1);
         n++;
      end
      check(tag, 32'(gif.btn_out != 4'b0000), 32'd1);
   endtask

   task automatic check_press(input string tag, input logic [3:0] exp);
      for (int k = 0; k < 4; k++) begin
         check(tag, 32'(gif.btn_out), 32'(exp));
         tick(1);
      end
      for (int k = 0; k < 4; k++) begin
         check("gap", 32'(gif.btn_out), 32'd0);
         tick(1);
      end
   endtask

   task automatic count_btn(input int cycles, output int hits);
      hits = 0;
      for (int k = 0; k < cycles; k++) begin
         tick(1);
         if (gif.btn_out != 4'b0000) hits++;
      end
   endtask

   logic [3:0] second_exp;
   int         hits;

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      go            = 1'b0;
      inject_fault  = 1'b0;
      gif.colour_in = 4'b0000;
      gif.state_in  = 2'b00;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      check("rst_btn",   32'(gif.btn_out),   32'd0);
      check("rst_start", 32'(gif.start_out), 32'd0);
      check("rst_len",   32'(seq_len),       32'd0);
      check("rst_err",   32'(err),           32'd0);
      check("rst_busy",  32'(busy),          32'd0);

      // single start strobe, second go edge ignored while busy
      go = 1'b1;
      hits = 0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         if (gif.start_out) hits++;
      end
      check("start_pulses", 32'(hits), 32'd1);
      check("busy_after_go", 32'(busy), 32'd1);
      go = 1'b0;
      tick(2);
      go = 1'b1;
      hits = 0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         if (gif.start_out) hits++;
      end
      check("start_ignored", 32'(hits), 32'd0);
      go = 1'b0;

      // capture red, yellow, blue and replay
      gif.state_in = 2'b01;
      tick(4);
      colour_event(4'b0001);
      colour_event(4'b0100);
      colour_event(4'b1000);
      check("len3", 32'(seq_len), 32'd3);
      gif.state_in = 2'b10;
      wait_press("press_seen0");
      check_press("press_red",    4'b0001);
      check_press("press_yellow", 4'b0100);
      check_press("press_blue",   4'b1000);
      check("waitchk_busy", 32'(busy), 32'd1);
      check("waitchk_btn",  32'(gif.btn_out), 32'd0);

      // next round, non-one-hot event
      gif.state_in = 2'b01;
      tick(4);
      check("round2_len", 32'(seq_len), 32'd0);
      check("round2_err", 32'(err), 32'd0);
      colour_event(4'b0011);
      check("multi_err", 32'(err), 32'd1);
      check("multi_len", 32'(seq_len), 32'd0);

      // abort from capture keeps err
      gif.state_in = 2'b00;
      tick(4);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_err",  32'(err),  32'd1);

      // overflow
      start_game();
      check("newgame_err", 32'(err), 32'd0);
      gif.state_in = 2'b01;
      tick(4);
      for (int k = 0; k < 16; k++) colour_event(4'b0001);
      check("full_len", 32'(seq_len), 32'd16);
      check("full_err", 32'(err), 32'd0);
      colour_event(4'b0010);
      check("ovf_len", 32'(seq_len), 32'd16);
      check("ovf_err", 32'(err), 32'd1);

      // empty sequence reaching WAIT
      gif.state_in = 2'b00;
      tick(4);
      start_game();
      gif.state_in = 2'b01;
      tick(4);
      gif.state_in = 2'b10;
      count_btn(12, hits);
      check("empty_nobtn", 32'(hits), 32'd0);
      check("empty_err",   32'(err),  32'd1);
      check("empty_busy",  32'(busy), 32'd1);

      // abort during gap
      gif.state_in = 2'b01;
      tick(4);
      colour_event(4'b0010);
      colour_event(4'b0100);
      check("gap_len", 32'(seq_len), 32'd2);
      gif.state_in = 2'b10;
      wait_press("press_seen1");
      for (int k = 0; k < 4; k++) begin
         check("press_green", 32'(gif.btn_out), 32'd2);
         tick(1);
      end
      gif.state_in = 2'b00;
      count_btn(10, hits);
      check("gap_abort_nobtn", 32'(hits), 32'd0);
      check("gap_abort_busy",  32'(busy), 32'd0);

      // fault injection, then reset mid-press
      start_game();
      gif.state_in = 2'b01;
      tick(4);
      colour_event(4'b0001);
      colour_event(4'b0010);
      inject_fault = 1'b1;
      gif.state_in = 2'b10;
      wait_press("press_seen2");
      check_press("fi_first", 4'b0001);
`ifdef AUTOPLAY_FAULT_INJECT_EN
      second_exp = 4'b0001;
`else
      second_exp = 4'b0010;
`endif
      for (int k = 0; k < 2; k++) begin
         check("fi_second", 32'(gif.btn_out), 32'(second_exp));
         tick(1);
      end
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("midrst_btn",  32'(gif.btn_out), 32'd0);
      check("midrst_len",  32'(seq_len),     32'd0);
      check("midrst_err",  32'(err),         32'd0);
      check("midrst_busy", 32'(busy),        32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
